// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the alarm-clock button front end.
package clk_ctrl_pkg;

  // Operating mode of the clock controller.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2
  } mode_t;

  // Bit positions of each push-button inside the packed button vectors.
  localparam int BTN_SET = 0;
  localparam int BTN_ALM = 1;
  localparam int BTN_MIN = 2;
  localparam int BTN_HRS = 3;
  localparam int BTN_DAY = 4;
  localparam int NUM_BTN = 5;

  // Which advance button currently owns the repeat engine.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_HRS  = 2'd2,
    SEL_DAY  = 2'd3
  } adv_sel_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Raw push-buttons in, clean mode levels and advance pulses out.
interface time_set_ctrl_if;
  logic btn_set;
  logic btn_alarm;
  logic btn_min;
  logic btn_hrs;
  logic btn_day;
  logic timeset;
  logic alarmset;
  logic minadv;
  logic hrsadv;
  logic dayadv;

  // Button source side (board / bench).
  modport master (
    output btn_set, btn_alarm, btn_min, btn_hrs, btn_day,
    input  timeset, alarmset, minadv, hrsadv, dayadv
  );

  // Controller side.
  modport slave (
    input  btn_set, btn_alarm, btn_min, btn_hrs, btn_day,
    output timeset, alarmset, minadv, hrsadv, dayadv
  );
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, counting debouncer, registered rise detect.
module btn_debounce #(
  parameter int DB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DB_CYC + 1);
  localparam logic [CW-1:0] CNT_TERM = CW'(DB_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          db_dly_q;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing samples; flip the level on the DB_CYC-th one.
  always_comb begin
    db_d    = db_q;
    cnt_d   = '0;
    press_d = db_q & ~db_dly_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_TERM) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer, debounce state and press register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign level = db_q;
  assign press = press_q;
endmodule

// File: rtl/time_set_ctrl.sv
// Mode FSM, idle timeout and hold-to-repeat advance generator.
module time_set_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DB_CYC  = 4,
  parameter int RPT_DLY = 8,
  parameter int RPT_PER = 3,
  parameter int IDLE_TO = 64
) (
  input  logic            clk,
  input  logic            rst,
  time_set_ctrl_if.slave  bus
);
  localparam int RW = $clog2(max2(RPT_DLY, RPT_PER) + 1);
  localparam int IW = $clog2(IDLE_TO + 1);

  logic [NUM_BTN-1:0] raw_vec, lvl_vec, prs_vec;

  assign raw_vec = {bus.btn_day, bus.btn_hrs, bus.btn_min, bus.btn_alarm, bus.btn_set};

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(.DB_CYC(DB_CYC)) u_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw_vec[gi]),
        .level (lvl_vec[gi]),
        .press (prs_vec[gi])
      );
    end
  endgenerate

  // Mode buttons only matter through their press events.
  logic unused_mode_lvl;
  assign unused_mode_lvl = lvl_vec[BTN_SET] ^ lvl_vec[BTN_ALM];

  mode_t         mode_q, mode_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          any_press, idle_hit, mode_chg;
  adv_sel_t      sel, act_q, act_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          fire;
  logic [2:0]    adv_q, adv_d;      // {day, hrs, min}
  logic          timeset_q, alarmset_q;

  assign any_press = |prs_vec;
  // A press in the terminal cycle counts as activity and cancels the timeout.
  assign idle_hit  = (mode_q != RUN) && (idle_q == IW'(IDLE_TO - 1)) && !any_press;

  // Next mode: SET_TIME wins a simultaneous set/alarm press from RUN.
  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      RUN: begin
        if (prs_vec[BTN_SET])      mode_d = SET_TIME;
        else if (prs_vec[BTN_ALM]) mode_d = SET_ALARM;
      end
      SET_TIME:  if (prs_vec[BTN_SET] || idle_hit) mode_d = RUN;
      SET_ALARM: if (prs_vec[BTN_ALM] || idle_hit) mode_d = RUN;
      default:   mode_d = RUN;
    endcase
    mode_chg = (mode_d != mode_q);
    if (mode_chg || (mode_q == RUN) || any_press) idle_d = '0;
    else                                          idle_d = idle_q + IW'(1);
  end

  // Highest-priority held advance button; day only while setting the time.
  always_comb begin
    sel = SEL_NONE;
    if (mode_q != RUN) begin
      if (lvl_vec[BTN_MIN])                              sel = SEL_MIN;
      else if (lvl_vec[BTN_HRS])                         sel = SEL_HRS;
      else if (lvl_vec[BTN_DAY] && mode_q == SET_TIME)   sel = SEL_DAY;
    end
  end

  // Repeat engine: pulse on a new owner, then after RPT_DLY, then every RPT_PER.
  always_comb begin
    act_d = act_q;
    rpt_d = rpt_q;
    fire  = 1'b0;
    if (mode_chg) begin
      act_d = SEL_NONE;
      rpt_d = '0;
    end else if (sel != act_q) begin
      act_d = sel;
      fire  = (sel != SEL_NONE);
      rpt_d = (sel != SEL_NONE) ? RW'(RPT_DLY) : '0;
    end else if (sel != SEL_NONE) begin
      if (rpt_q == RW'(1)) begin
        fire  = 1'b1;
        rpt_d = RW'(RPT_PER);
      end else if (rpt_q != '0) begin
        rpt_d = rpt_q - RW'(1);
      end
    end
    adv_d = fire ? {sel == SEL_DAY, sel == SEL_HRS, sel == SEL_MIN} : 3'b000;
  end

  // Mode FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= RUN;
      idle_q     <= '0;
      act_q      <= SEL_NONE;
      rpt_q      <= '0;
      adv_q      <= 3'b000;
      timeset_q  <= 1'b0;
      alarmset_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      idle_q     <= idle_d;
      act_q      <= act_d;
      rpt_q      <= rpt_d;
      adv_q      <= adv_d;
      timeset_q  <= (mode_d == SET_TIME);
      alarmset_q <= (mode_d == SET_ALARM);
    end
  end

  assign bus.timeset  = timeset_q;
  assign bus.alarmset = alarmset_q;
  assign bus.minadv   = adv_q[0];
  assign bus.hrsadv   = adv_q[1];
  assign bus.dayadv   = adv_q[2];
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Input-side front end for the alarm-clock datapath. It turns raw, bouncy push-buttons into the clean mode levels and single-cycle advance enables that the time and alarm counters consume.
- Counterpart of the counter/display chain: the chain consumes timeset, alarmset and *adv; this block produces them.
- Contents: per-button synchronizer and debouncer, a mode FSM (RUN / SET_TIME / SET_ALARM), hold-to-repeat advance generation, and an idle timeout back to RUN.

Parameters:
- DB_CYC, 4: consecutive stable synchronized cycles required before a debounced level changes (>=1).
- RPT_DLY, 8: cycles a held advance button must stay held after its first pulse before auto-repeat starts.
- RPT_PER, 3: cycles between auto-repeat pulses (>=1).
- IDLE_TO, 64: cycles without any debounced press in a set mode before forcing RUN.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_set  in  1  raw, asynchronous; toggles time-set mode.
- btn_alarm  in  1  raw, asynchronous; toggles alarm-set mode.
- btn_min  in  1  raw, asynchronous; advance minutes.
- btn_hrs  in  1  raw, asynchronous; advance hours.
- btn_day  in  1  raw, asynchronous; advance day (time-set mode only).
- timeset  out  1  level, high in SET_TIME.
- alarmset  out  1  level, high in SET_ALARM.
- minadv  out  1  one-cycle advance pulse.
- hrsadv  out  1  one-cycle advance pulse.
- dayadv  out  1  one-cycle advance pulse.

Behaviour:
- Reset (rst=0, async): FSM=RUN, all outputs 0, synchronizers 0, debounced levels 0, all counters 0. Outputs stay 0 on the first clock after release.
- Input path, per button:
  - 2-flop synchronizer.
  - Debounced level db flips after the synchronized value differs from db for DB_CYC consecutive cycles. Any agreeing cycle clears the count.
  - Press event = db rising, one cycle.
  - Raw high sampled at edge k gives the press event at edge k+DB_CYC+2. Registered outputs appear one cycle later (edge k+DB_CYC+3 = 7 at defaults).
- FSM transitions on press events:
  - RUN: set press goes to SET_TIME. Alarm press goes to SET_ALARM. Both in the same cycle: SET_TIME wins.
  - SET_TIME: set press goes to RUN. Alarm press is ignored.
  - SET_ALARM: alarm press goes to RUN. Set press is ignored.
  - In either set mode, an idle counter increments each cycle and clears on any press event. When it reaches IDLE_TO-1 the next state is RUN.
- Outputs are registered: timeset = (state==SET_TIME), alarmset = (state==SET_ALARM).
- Advance selection:
  - Only in SET_TIME or SET_ALARM. In RUN, advance buttons produce no pulses.
  - dayadv is never asserted in SET_ALARM.
  - Active advance button = highest-priority held db among min > hrs > day, with day eligible only in SET_TIME. At most one *adv is high per cycle.
- Repeat engine:
  - When the active button changes (including from none), emit one pulse for the new active button and load a delay counter with RPT_DLY.
  - After RPT_DLY cycles still held, pulse, then pulse again every RPT_PER cycles while held.
  - Release or change of the active button restarts the sequence.
- Pulses are registered; each is high for exactly one cycle.
- Mode change: any FSM transition clears the repeat engine and the idle counter. An advance button held across a mode entry produces its first pulse one cycle after entry, not earlier.
- Reset mid-hold: everything returns to reset values immediately. After release, a still-held button must re-debounce (DB_CYC+3 cycles) before it has any effect.
- Counter widths: $clog2(max(param)+1). Terminal counts compare equal, with no wrap beyond the terminal count.

Decomposition:
- Package clk_ctrl_pkg:
  - typedef enum logic[1:0] mode_t {RUN, SET_TIME, SET_ALARM}.
  - Button index localparams for SET, ALM, MIN, HRS, DAY.
  - Advance-select enum {NONE, MIN, HRS, DAY}.
- Sub-module btn_debounce #(DB_CYC):
  - Contains synchronizer, debouncer and rise detect.
  - Ports: clk, rst, raw, level, press.
  - Instantiated 5x.

Test Plan (defaults):
1. Release reset, hold btn_set for 20 cycles with 3 cycles of bounce at the start -> exactly one transition; timeset=1 at edge 7 after stable-high sampling; no *adv pulses.
2. In SET_TIME, hold btn_min for 30 cycles -> minadv pulses at relative cycles 0, 8, 11, 14, 17, 20, 23, 26, 29, then none after release; hrsadv and dayadv stay 0.
3. In SET_ALARM, hold btn_day then btn_hrs together -> dayadv never asserts; hrsadv pulses; releasing hrs gives no further pulses.
4. In RUN, press btn_set and btn_alarm in the same cycle -> state SET_TIME, alarmset=0. Then press btn_alarm -> remains SET_TIME.
5. Enter SET_TIME and wait 64 cycles with no press -> timeset falls. A press at cycle 50 instead keeps SET_TIME until 64 cycles after that press.
6. Assert rst during an auto-repeat hold -> all outputs 0 asynchronously. Release rst with the button still held -> no pulse until the re-debounce completes.
